stopwatch_clock: RTL and testbench
==================================

# stopwatch_clock

Clock-enable/clock-divider block for the FPGA stopwatch. It derives four slow, 50%-duty square waves from the single board oscillator `masterClk`:
- a count-increment clock;
- an adjust-mode clock;
- a display-multiplex (fast) clock;
- a blink clock.

Downstream counter, adjust and seven-segment logic consume these signals.

## Interface
Parameters:
- `MASTER_HZ`, 100_000_000: frequency of `masterClk` in Hz.
- `INC_HZ`, 1: `incClk` frequency, the normal stopwatch count rate.
- `ADJ_HZ`, 2: `adjClk` frequency, the count rate in adjust mode.
- `FAST_HZ`, 500: `fastClk` frequency, the seven-segment digit-multiplex rate.
- `BLINK_HZ`, 4: `blinkClk` frequency, the blink rate of selected digits in adjust mode.

Ports:
- `masterClk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `adjClk` output, 1 bit: square wave at `ADJ_HZ`.
- `incClk` output, 1 bit: square wave at `INC_HZ`.
- `fastClk` output, 1 bit: square wave at `FAST_HZ`.
- `blinkClk` output, 1 bit: square wave at `BLINK_HZ`.

## Operation
- There are four independent divider channels with identical structure. For a channel of frequency F:
  - HALF = MASTER_HZ / (2*F), using integer division with truncation.
  - The counter width is clog2(HALF), with a minimum of 1 bit.
- Each channel has one counter `cnt` and one output register `out`.
  - On each `masterClk` rising edge, if `cnt == HALF-1`, then `cnt <= 0` and `out <= ~out`.
  - Otherwise, `cnt <= cnt + 1`.
- Each output is driven directly from its flop. There is no combinational path from the counters to the outputs, so the outputs are glitch-free.
- Duty cycle is exactly 50%. Output period is exactly 2*HALF `masterClk` cycles.
- There is no phase relationship between channels beyond the shared reset release.
- Reset, asynchronous: while `rst` is 1, every `cnt` is 0 and `adjClk`, `incClk`, `fastClk` and `blinkClk` are all 0, regardless of `masterClk`.
- Parameter legality: HALF must be at least 1 for every channel, i.e. F ≤ MASTER_HZ/2. Elaboration must fail (`$error` in a generate check) if this is violated.
- HALF = 1 gives `out` toggling on every edge, i.e. MASTER_HZ/2.

## Timing
- Reset assertion clears outputs immediately; no clock edge is needed.
- Reset mid-operation aborts the current half-period. After release, the channel restarts from `cnt` = 0 and output 0.
- After `rst` deasserts, the first `masterClk` rising edge increments `cnt` to 1.
- Each output's first 0→1 transition occurs on the HALF-th rising edge after release.
- Subsequent transitions occur every HALF edges.
- With default parameters:

| Output | HALF (masterClk cycles) | Period |
|---|---|---|
| `incClk` | 50_000_000 | 1 s |
| `adjClk` | 25_000_000 | 0.5 s |
| `fastClk` | 100_000 | 2 ms |
| `blinkClk` | 12_500_000 | 0.25 s |

- The counter wrap and the output toggle happen on the same edge. `cnt` never exceeds HALF-1.
- Outputs change only on `masterClk` rising edges, with one flop clock-to-q delay. There are no gated clocks inside the block.

## Test plan
All scenarios use a 10 ns `masterClk` and `MASTER_HZ`=100, `INC_HZ`=1, `ADJ_HZ`=2, `FAST_HZ`=10, `BLINK_HZ`=5.

1. Hold `rst`=1 for 10 ns from time 0 -> all four outputs read 0 throughout, including across clock edges.
2. Release `rst` at 10 ns -> `fastClk` rises on the 5th posedge after release and then toggles every 50 ns, giving a 100 ns period. Log each `fastClk` rising edge time to confirm the spacing.
3. Run 2000 cycles -> measured half-periods are exactly:
   - `incClk`: 50 cycles;
   - `adjClk`: 25 cycles;
   - `blinkClk`: 10 cycles;
   - `fastClk`: 5 cycles.

   Every channel has an equal high and low count.
4. Assert `rst` asynchronously mid-cycle (not on a clock edge) while `incClk`=1 -> all outputs go to 0 immediately. After release, `incClk` rises again 50 posedges later.
5. Set `FAST_HZ`=50 (HALF=1) -> `fastClk` toggles on every posedge after release.
6. Set `FAST_HZ`=60 (HALF=0) -> elaboration fails with an error.

Source files
------------

// File: rtl/stopwatch_clock.sv
// rtl/stopwatch_clock.sv - four free-running 50%-duty clock-enable dividers for the stopwatch
// Each channel toggles a flop every HALF = MASTER_HZ/(2*F) masterClk edges.

module stopwatch_clock_div #(
  parameter int unsigned HALF = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic out_o
);

  localparam int unsigned W = (HALF > 1) ? $clog2(HALF) : 1;

  if (HALF < 1) begin : g_half_check
    $error("stopwatch_clock_div: HALF must be at least 1 (channel frequency above MASTER_HZ/2)");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    out_d = out_q;
    if (cnt_q == W'(HALF - 1)) begin
      cnt_d = '0;
      out_d = ~out_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

module stopwatch_clock #(
  parameter int unsigned MASTER_HZ = 100_000_000,
  parameter int unsigned INC_HZ    = 1,
  parameter int unsigned ADJ_HZ    = 2,
  parameter int unsigned FAST_HZ   = 500,
  parameter int unsigned BLINK_HZ  = 4
) (
  input  logic masterClk,
  input  logic rst,
  output logic adjClk,
  output logic incClk,
  output logic fastClk,
  output logic blinkClk
);

  // A zero frequency maps to HALF = 0 so the channel's legality check fires.
  function automatic int unsigned half_of(input int unsigned f);
    return (f == 0) ? 0 : MASTER_HZ / (2 * f);
  endfunction

  localparam int unsigned INC_HALF   = half_of(INC_HZ);
  localparam int unsigned ADJ_HALF   = half_of(ADJ_HZ);
  localparam int unsigned FAST_HALF  = half_of(FAST_HZ);
  localparam int unsigned BLINK_HALF = half_of(BLINK_HZ);

  stopwatch_clock_div #(.HALF(INC_HALF)) u_inc (
    .clk_i (masterClk),
    .rst_i (rst),
    .out_o (incClk)
  );

  stopwatch_clock_div #(.HALF(ADJ_HALF)) u_adj (
    .clk_i (masterClk),
    .rst_i (rst),
    .out_o (adjClk)
  );

  stopwatch_clock_div #(.HALF(FAST_HALF)) u_fast (
    .clk_i (masterClk),
    .rst_i (rst),
    .out_o (fastClk)
  );

  stopwatch_clock_div #(.HALF(BLINK_HALF)) u_blink (
    .clk_i (masterClk),
    .rst_i (rst),
    .out_o (blinkClk)
  );

endmodule

// File: tb/tb_stopwatch_clock.sv
// tb/tb_stopwatch_clock.sv - scoreboard bench for stopwatch_clock divider channels
// Expected toggle edges are queued at reset release and consumed as outputs change.

module tb_stopwatch_clock;

  logic masterClk = 1'b0;
  logic rst       = 1'b1;
  logic adjClk, incClk, fastClk, blinkClk;
  logic adjClk2, incClk2, fastClk2, blinkClk2;

  always #5 masterClk = ~masterClk;

  stopwatch_clock #(
    .MASTER_HZ (100), .INC_HZ (1), .ADJ_HZ (2), .FAST_HZ (10), .BLINK_HZ (5)
  ) dut (
    .masterClk (masterClk), .rst (rst),
    .adjClk (adjClk), .incClk (incClk), .fastClk (fastClk), .blinkClk (blinkClk)
  );

  stopwatch_clock #(
    .MASTER_HZ (100), .INC_HZ (1), .ADJ_HZ (2), .FAST_HZ (50), .BLINK_HZ (5)
  ) dut_h1 (
    .masterClk (masterClk), .rst (rst),
    .adjClk (adjClk2), .incClk (incClk2), .fastClk (fastClk2), .blinkClk (blinkClk2)
  );

  localparam int NCH = 8;
  localparam int HALVES [NCH] = '{50, 25, 5, 10, 1, 50, 25, 10};

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  bit    running  = 1'b0;
  int    exp_q [NCH][$];
  int    hi_cnt [NCH];
  int    lo_cnt [NCH];
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] obs;

  assign obs = {blinkClk2, adjClk2, incClk2, fastClk2, blinkClk, fastClk, adjClk, incClk};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic arm_release(input int horizon);
    for (int i = 0; i < NCH; i++) begin
      exp_q[i].delete();
      hi_cnt[i] = 0;
      lo_cnt[i] = 0;
      for (int k = HALVES[i]; k <= horizon; k += HALVES[i]) exp_q[i].push_back(k);
    end
    prev_q  = '0;
    cyc     = 0;
    rst     = 1'b0;
    running = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, int'(obs), 0);
  endtask

  always @(posedge masterClk) if (running) cyc++;

  always @(negedge masterClk) begin
    if (running && cyc > 0) begin
      for (int i = 0; i < NCH; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
          check($sformatf("missed_toggle_ch%0d", i), cyc, exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        if (obs[i] !== prev_q[i]) begin
          if (exp_q[i].size() == 0) check($sformatf("extra_toggle_ch%0d", i), cyc, -1);
          else check($sformatf("toggle_ch%0d", i), cyc, exp_q[i].pop_front());
          if (i == 2 && obs[i]) $display("fastClk rise at %0t (edge %0d)", $time, cyc);
        end
        if (obs[i]) hi_cnt[i]++;
        else lo_cnt[i]++;
      end
      prev_q = obs;
    end
  end

  initial begin
    int waited;
    #1 check_all_zero("rst_t1");
    #5 check_all_zero("rst_after_edge");
    #3 check_all_zero("rst_t9");
    #1 arm_release(2000);

    repeat (2000) @(posedge masterClk);
    #7;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("hi_cnt_ch%0d", i), hi_cnt[i], 1000);
      check($sformatf("lo_cnt_ch%0d", i), lo_cnt[i], 1000);
      if (exp_q[i].size() > 0) check($sformatf("pending_ch%0d", i), exp_q[i][0], 2001);
    end
    running = 1'b0;

    waited = 0;
    while (incClk !== 1'b1 && waited < 200) begin
      @(posedge masterClk);
      #3;
      waited++;
    end
    check("inc_high_before_rst", int'(incClk), 1);
    rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (3) begin
      @(posedge masterClk);
      #1 check_all_zero("rst_hold");
    end
    @(negedge masterClk);
    arm_release(120);

    repeat (120) @(posedge masterClk);
    #7;
    for (int i = 0; i < NCH; i++)
      if (exp_q[i].size() > 0) check($sformatf("pending2_ch%0d", i), exp_q[i][0], 121);
    check("inc_after_rerelease", int'(incClk), 0);
    check("fast_h1_after_rerelease", int'(fastClk2), 0);
    running = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
